pwm_duty_ramp_ctrl: RTL
=======================

Name: pwm_duty_ramp_ctrl

Overview:
Controller that owns the DUTY_CYCLE setting of the PWM datapath and sequences every change to it. It accepts absolute setpoints over a valid/ready handshake and single-step inc/dec commands from the debounced buttons. It rate-limits each change into a ±1 ramp and commits updates only on PWM period boundaries, so the datapath never sees a mid-period duty change (glitch-free output).

Parameters:
DUTY_W, 4, width of duty value and setpoint
DUTY_MAX, 10, highest legal duty (10 = 100% with a 10-step PWM period)
DUTY_INIT, 5, duty value after reset (50%)
STEP_PERIODS, 4, number of PWM periods between consecutive ramp steps (≥1)
CNT_W, 8, width of the internal period counter (must hold STEP_PERIODS-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  1 = ramping allowed; 0 = abort ramp, hold duty
period_start  in  1  one-cycle pulse from PWM datapath when its counter wraps to 0
target_duty  in  DUTY_W  requested absolute duty
target_valid  in  1  setpoint request
target_ready  out  1  setpoint accepted when valid&ready
inc_req  in  1  one-cycle debounced increase pulse
dec_req  in  1  one-cycle debounced decrease pulse
duty_cycle  out  DUTY_W  registered duty driven to PWM datapath
busy  out  1  1 while in RAMP
at_target  out  1  duty_cycle == latched target

Behaviour:
- Reset (async, immediate): duty_cycle=DUTY_INIT, target_reg=DUTY_INIT, state=IDLE, period cnt=0, pending inc/dec cleared, busy=0, target_ready=1, at_target=1.
- Clock: one domain (clk). The duty_cycle register changes only on a clk edge where period_start=1. The new value is visible the following cycle.
- FSM states: IDLE, RAMP.
- IDLE:
  - target_ready=1.
  - On target_valid&target_ready&enable:
    - Latch target_reg = min(target_duty, DUTY_MAX).
    - If the clamped target ≠ duty_cycle, go to RAMP with cnt=0. Otherwise stay in IDLE.
  - inc_req and dec_req set a single pending flag. The newest request overwrites the older one.
  - inc_req and dec_req in the same cycle cancel each other and clear any pending flag.
  - On period_start with a pending flag: duty ±1, saturating at 0 and DUTY_MAX. target_reg follows the new duty. The flag clears.
  - A setpoint accepted in the same cycle as inc/dec wins; pending flags are cleared.
- RAMP:
  - target_ready=0 and busy=1. inc_req/dec_req are ignored (not queued).
  - On each period_start: if cnt==STEP_PERIODS-1, duty steps 1 toward target_reg and cnt=0; else cnt+1.
  - After the step that makes duty==target_reg, go to IDLE on the same edge. busy falls the next cycle.
- enable=0: in RAMP, go to IDLE next edge, hold duty, set target_reg=duty_cycle, clear cnt. In IDLE, setpoint handshakes still complete (ready=1) but are discarded; inc/dec are ignored.
- Arithmetic: all unsigned DUTY_W. Saturation is checked before add/sub, so there is no wrap at 0 or DUTY_MAX.
- period_start with no work pending: no change.
- at_target is combinational: duty_cycle==target_reg.

Optional Feature:
Macro PWM_DUTY_RAMP_SOFTSTART_EN.
- Defined: reset loads duty_cycle=0, target_reg=DUTY_INIT, state=RAMP, busy=1, target_ready=0. After reset deassertion, duty ramps 0→DUTY_INIT at the STEP_PERIODS rate, then enters IDLE. The enable=0 abort applies as normal.
- Not defined: reset behaviour is exactly as in Behaviour (duty=DUTY_INIT, IDLE).

Test Plan:
1. Defaults with STEP_PERIODS=2, period_start every 10 clk. Send setpoint 8 → ready drops next cycle, duty goes 6/7/8 after the 2nd/4th/6th period_start, then busy=0, ready=1, at_target=1.
2. Setpoint 15 from duty 5 → clamped target 10, ramp ends at duty 10, never above. Then inc_req + period_start → duty stays 10.
3. From duty 0 (via setpoint 0): dec_req → duty stays 0. Then inc_req and dec_req in the same cycle → no change after the next two period_start pulses.
4. inc_req mid-period at duty 5 → duty still 5 until period_start, becomes 6 exactly one cycle after that period_start edge, with no change between boundaries.
5. Mid-ramp (5→9, at duty 7): enable=0 → IDLE next edge, duty held at 7, at_target=1, ready=1. Next, rst asserted mid-ramp → duty=5 immediately (async), busy=0.
6. With PWM_DUTY_RAMP_SOFTSTART_EN and STEP_PERIODS=1: release reset → duty=0, busy=1, then duty 1..5 on consecutive period_start pulses, then IDLE.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl: owns the PWM duty setting, turning setpoints and inc/dec buttons into
// +/-1 steps committed only on period boundaries. Define PWM_DUTY_RAMP_SOFTSTART_EN to ramp 0->DUTY_INIT after reset.
module pwm_duty_ramp_ctrl #(
    parameter int unsigned DUTY_W       = 4,
    parameter int unsigned DUTY_MAX     = 10,
    parameter int unsigned DUTY_INIT    = 5,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              period_start,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic              inc_req,
    input  logic              dec_req,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              busy,
    output logic              at_target
);

    localparam logic [DUTY_W-1:0] DMAX     = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DINIT    = DUTY_W'(DUTY_INIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_PERIODS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

`ifdef PWM_DUTY_RAMP_SOFTSTART_EN
    localparam logic [DUTY_W-1:0] RST_DUTY = '0;
    localparam logic              RST_RAMP = (DUTY_INIT != 0);
`else
    localparam logic [DUTY_W-1:0] RST_DUTY = DINIT;
    localparam logic              RST_RAMP = 1'b0;
`endif
    localparam state_t RST_STATE = RST_RAMP ? RAMP : IDLE;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              pend_inc;
    logic              pend_dec;
    logic [DUTY_W-1:0] target_reg;

    logic [DUTY_W-1:0] clamped;
    logic              eff_inc;
    logic              eff_dec;
    logic [DUTY_W-1:0] bump;
    logic [DUTY_W-1:0] ramp_step;

    // Newest button request overrides the pending one; both together cancel.
    always_comb begin
        clamped = target_duty;
        if (target_duty > DMAX) clamped = DMAX;

        eff_inc = pend_inc;
        eff_dec = pend_dec;
        if (inc_req && dec_req) begin
            eff_inc = 1'b0;
            eff_dec = 1'b0;
        end else if (inc_req) begin
            eff_inc = 1'b1;
            eff_dec = 1'b0;
        end else if (dec_req) begin
            eff_inc = 1'b0;
            eff_dec = 1'b1;
        end

        // Saturation is decided before the add/sub so the value never wraps.
        bump = duty_cycle;
        if (eff_inc && (duty_cycle < DMAX)) bump = duty_cycle + DUTY_W'(1);
        else if (eff_dec && (duty_cycle != '0)) bump = duty_cycle - DUTY_W'(1);

        ramp_step = (duty_cycle < target_reg) ? duty_cycle + DUTY_W'(1)
                                              : duty_cycle - DUTY_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RST_STATE;
            duty_cycle   <= RST_DUTY;
            target_reg   <= DINIT;
            cnt          <= '0;
            pend_inc     <= 1'b0;
            pend_dec     <= 1'b0;
            busy         <= RST_RAMP;
            target_ready <= ~RST_RAMP;
        end else begin
            case (state)
                IDLE: begin
                    if (!enable) begin
                        pend_inc <= 1'b0;
                        pend_dec <= 1'b0;
                    end else if (target_valid && target_ready) begin
                        target_reg <= clamped;
                        pend_inc   <= 1'b0;
                        pend_dec   <= 1'b0;
                        if (clamped != duty_cycle) begin
                            state        <= RAMP;
                            cnt          <= '0;
                            busy         <= 1'b1;
                            target_ready <= 1'b0;
                        end
                    end else if (period_start && (eff_inc || eff_dec)) begin
                        duty_cycle <= bump;
                        target_reg <= bump;
                        pend_inc   <= 1'b0;
                        pend_dec   <= 1'b0;
                    end else begin
                        pend_inc <= eff_inc;
                        pend_dec <= eff_dec;
                    end
                end
                RAMP: begin
                    if (!enable) begin
                        state        <= IDLE;
                        target_reg   <= duty_cycle;
                        cnt          <= '0;
                        busy         <= 1'b0;
                        target_ready <= 1'b1;
                    end else if (period_start) begin
                        if (cnt == CNT_LAST) begin
                            duty_cycle <= ramp_step;
                            cnt        <= '0;
                            if (ramp_step == target_reg) begin
                                state        <= IDLE;
                                busy         <= 1'b0;
                                target_ready <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign at_target = (duty_cycle == target_reg);

endmodule
